pwm_duty_ctrl_f: RTL and testbench
==================================

PWM_DUTY_CTRL_F -- requirements
Module: pwm_duty_ctrl_f

Interface
REQ-001 Parameter DEB_CNT, default 16: clock cycles an input must be stable before a press or release is accepted (>=2).
REQ-002 Parameter PRESC, default 4: clock cycles per PWM tick (>=1).
REQ-003 clk_f  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_f  input  1  reset; asynchronous, active-high.
REQ-005 up_f  input  1  raw "increase duty" button, asynchronous to clk_f, bouncy.
REQ-006 down_f  input  1  raw "decrease duty" button, asynchronous to clk_f, bouncy.
REQ-007 enable_f  input  1  high = button presses may change the level; low = level frozen.
REQ-008 level_f  output  3  requested duty level, 0..7.
REQ-009 duty_f  output  3  duty level currently applied to the PWM.
REQ-010 pwm_f  output  1  PWM waveform.
REQ-011 sat_f  output  1  one-cycle pulse: accepted press rejected at a limit.

Function
REQ-012 Each of up_f/down_f SHALL pass through a two-flop synchronizer before any use.
REQ-013 Each synchronized button SHALL have its own debounce FSM: IDLE, ARM, HELD, REL.
REQ-014 IDLE -> ARM when input=1 (counter cleared); ARM -> IDLE when input=0.
REQ-015 ARM -> HELD after DEB_CNT consecutive input=1 cycles; emit one-cycle press pulse on this transition.
REQ-016 HELD -> REL when input=0 (counter cleared); REL -> HELD when input=1.
REQ-017 REL -> IDLE after DEB_CNT consecutive input=0 cycles; no pulse on release.
REQ-018 Latency, raw edge to press pulse: exactly DEB_CNT+3 clocks; press pulse to level_f update: 1 clock.
REQ-019 Holding a button SHALL produce exactly one press pulse (no auto-repeat).
REQ-020 enable_f=1, up pulse only: level_f+1 if level_f<7; else level_f holds and sat_f pulses.
REQ-021 enable_f=1, down pulse only: level_f-1 if level_f>0; else level_f holds and sat_f pulses.
REQ-022 Up and down pulses in the same cycle: level_f unchanged, no sat_f.
REQ-023 enable_f=0: press pulses are discarded (not queued); debounce FSMs and PWM keep running; sat_f stays 0.
REQ-024 Arithmetic is saturating 3-bit; level_f never wraps 7->0 or 0->7.
REQ-025 Prescaler counts 0..PRESC-1; tick asserted for one cycle when count = PRESC-1, then wraps to 0.
REQ-026 3-bit PWM counter advances on each tick, wrapping 7->0; PWM period = 8*PRESC clocks.
REQ-027 duty_f SHALL load level_f only on the tick where the PWM counter wraps 7->0 (glitch-free update at period boundary).
REQ-028 pwm_f = 1 iff PWM counter < duty_f; duty 0 -> constant 0; duty 7 -> high 7/8 of period.
REQ-029 pwm_f and sat_f SHALL be driven from registers or register-only logic (no input-to-output combinational path).

Reset
REQ-030 reset_f=1 SHALL immediately clear synchronizers, FSMs (to IDLE), counters, prescaler, level_f=0, duty_f=0, pwm_f=0, sat_f=0.
REQ-031 A press in progress when reset asserts is discarded; a button still held at reset release is debounced from scratch.

Verification (DEB_CNT=4, PRESC=2, period 16 clocks)
REQ-032 Reset: assert reset_f mid-run -> all outputs 0 within the same cycle, pwm_f low until duty_f>0.
REQ-033 Three clean up presses (held 10 clocks, gaps 10 clocks) -> level_f=3 at 8 clocks after each raw edge; duty_f=3 at next PWM wrap; pwm_f high 6 of every 16 clocks.
REQ-034 up_f high 3 clocks only, plus bounce 1-0-1 pattern shorter than 4 stable cycles -> level_f unchanged, no pulses.
REQ-035 level_f=7, up press -> level_f stays 7, sat_f high exactly 1 clock; at level 0, down press -> same.
REQ-036 up_f and down_f rise on same clock, enable_f=1 -> level_f unchanged, sat_f=0; with enable_f=0 one up press -> level_f unchanged.
REQ-037 Reset pulsed while up_f held in ARM, up_f still high after release -> single level_f increment exactly DEB_CNT+4 clocks after reset deassertion.

Source files
------------

// File: rtl/pwm_duty_ctrl_f.sv
// Button-controlled PWM duty controller: synchronized and debounced up/down buttons
// adjust a saturating 3-bit level that is applied to the PWM at period boundaries.

// Debounce FSM for one synchronized button; emits a one-cycle press pulse.
//   state  | meaning
//   S_IDLE | released and stable
//   S_ARM  | input high, qualifying the press
//   S_HELD | press accepted, button held
//   S_REL  | input low, qualifying the release
module pwm_duty_ctrl_f_deb #(
  parameter int DEB_CNT = 16
) (
  input  logic clk_f,
  input  logic reset_f,
  input  logic in_f,
  output logic press_f
);

  localparam int CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] LOAD = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_REL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt;

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      state   <= S_IDLE;
      cnt     <= '0;
      press_f <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      press_f <= press_nxt;
    end
  end

  // Stability timer is a down-counter restarted on entry to ARM/REL.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_f) begin
          state_nxt = S_ARM;
          cnt_nxt   = LOAD;
        end
      end
      S_ARM: begin
        if (!in_f) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HELD: begin
        if (!in_f) begin
          state_nxt = S_REL;
          cnt_nxt   = LOAD;
        end
      end
      S_REL: begin
        if (in_f) begin
          state_nxt = S_HELD;
        end else if (cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

module pwm_duty_ctrl_f #(
  parameter int DEB_CNT = 16,
  parameter int PRESC   = 4
) (
  input  logic       clk_f,
  input  logic       reset_f,
  input  logic       up_f,
  input  logic       down_f,
  input  logic       enable_f,
  output logic [2:0] level_f,
  output logic [2:0] duty_f,
  output logic       pwm_f,
  output logic       sat_f
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(PRESC - 1);

  logic [1:0]    up_sync, down_sync;
  logic          up_press, down_press;
  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic [2:0]    pwm_cnt;
  logic          up_ok, down_ok;

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      up_sync   <= 2'b00;
      down_sync <= 2'b00;
    end else begin
      up_sync   <= {up_sync[0], up_f};
      down_sync <= {down_sync[0], down_f};
    end
  end

  pwm_duty_ctrl_f_deb #(.DEB_CNT(DEB_CNT)) u_deb_up (
    .clk_f   (clk_f),
    .reset_f (reset_f),
    .in_f    (up_sync[1]),
    .press_f (up_press)
  );

  pwm_duty_ctrl_f_deb #(.DEB_CNT(DEB_CNT)) u_deb_down (
    .clk_f   (clk_f),
    .reset_f (reset_f),
    .in_f    (down_sync[1]),
    .press_f (down_press)
  );

  // Simultaneous up and down presses cancel.
  assign up_ok   = enable_f && up_press && !down_press;
  assign down_ok = enable_f && down_press && !up_press;

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      level_f <= 3'd0;
      sat_f   <= 1'b0;
    end else begin
      sat_f <= 1'b0;
      if (up_ok) begin
        if (level_f != 3'd7) level_f <= level_f + 3'd1;
        else                 sat_f   <= 1'b1;
      end else if (down_ok) begin
        if (level_f != 3'd0) level_f <= level_f - 3'd1;
        else                 sat_f   <= 1'b1;
      end
    end
  end

  assign tick = (presc_cnt == PRESC_TC);

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      presc_cnt <= '0;
      pwm_cnt   <= 3'd0;
      duty_f    <= 3'd0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 3'd1;
        // New duty takes effect only as a fresh period starts.
        if (pwm_cnt == 3'd7) duty_f <= level_f;
      end
    end
  end

  assign pwm_f = (pwm_cnt < duty_f);

endmodule

// File: tb/tb_pwm_duty_ctrl_f.sv
// Directed bench for pwm_duty_ctrl_f with DEB_CNT=4, PRESC=2 (16-clock PWM period).
module tb_pwm_duty_ctrl_f;

  logic       clk_f = 1'b0;
  logic       reset_f;
  logic       up_f, down_f, enable_f;
  logic [2:0] level_f, duty_f;
  logic       pwm_f, sat_f;

  int n_run  = 0;
  int n_fail = 0;

  pwm_duty_ctrl_f #(.DEB_CNT(4), .PRESC(2)) dut (
    .clk_f    (clk_f),
    .reset_f  (reset_f),
    .up_f     (up_f),
    .down_f   (down_f),
    .enable_f (enable_f),
    .level_f  (level_f),
    .duty_f   (duty_f),
    .pwm_f    (pwm_f),
    .sat_f    (sat_f)
  );

  always #5 clk_f = ~clk_f;

  task automatic step(input int n);
    repeat (n) @(posedge clk_f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raw edge at step 0; press pulse after clock 7, level update after clock 8.
  task automatic press(input logic u, input logic d, input logic [2:0] lvl_before,
                       input logic [2:0] lvl_after, input logic exp_sat);
    up_f   = u;
    down_f = d;
    step(7);
    chk("level_before_update", {5'd0, level_f}, {5'd0, lvl_before});
    chk("sat_before_update", {7'd0, sat_f}, 8'd0);
    step(1);
    chk("level_after_update", {5'd0, level_f}, {5'd0, lvl_after});
    chk("sat_at_update", {7'd0, sat_f}, {7'd0, exp_sat});
    step(1);
    chk("sat_one_cycle", {7'd0, sat_f}, 8'd0);
    step(1);
    up_f   = 1'b0;
    down_f = 1'b0;
    step(10);
    chk("level_no_repeat", {5'd0, level_f}, {5'd0, lvl_after});
  endtask

  initial begin
    int hi_cnt;
    int sat_cnt;
    logic first_hi, seventh_hi;
    logic pwm_leak;

    reset_f  = 1'b1;
    up_f     = 1'b0;
    down_f   = 1'b0;
    enable_f = 1'b1;
    step(2);
    chk("reset_level", {5'd0, level_f}, 8'd0);
    chk("reset_duty", {5'd0, duty_f}, 8'd0);
    chk("reset_pwm", {7'd0, pwm_f}, 8'd0);
    chk("reset_sat", {7'd0, sat_f}, 8'd0);
    reset_f = 1'b0;
    step(3);

    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 3'(i), 3'(i + 1), 1'b0);

    // Wait for the period boundary that applies duty 3, then check one full period.
    for (int i = 0; i < 40 && duty_f != 3'd3; i++) step(1);
    chk("duty_applied", {5'd0, duty_f}, 8'd3);
    hi_cnt = 0;
    first_hi = pwm_f;
    seventh_hi = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pwm_f) hi_cnt++;
      if (i == 6) seventh_hi = pwm_f;
      step(1);
    end
    chk("pwm_high_count", 8'(hi_cnt), 8'd6);
    chk("pwm_period_start_high", {7'd0, first_hi}, 8'd1);
    chk("pwm_low_after_6", {7'd0, seventh_hi}, 8'd0);

    // Short press plus bounce never qualifies.
    sat_cnt = 0;
    up_f = 1'b1; step(3);
    up_f = 1'b0; step(1);
    up_f = 1'b1; step(1);
    up_f = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (sat_f) sat_cnt++;
      step(1);
    end
    chk("bounce_level", {5'd0, level_f}, 8'd3);
    chk("bounce_no_sat", 8'(sat_cnt), 8'd0);

    for (int i = 3; i < 7; i++) press(1'b1, 1'b0, 3'(i), 3'(i + 1), 1'b0);
    press(1'b1, 1'b0, 3'd7, 3'd7, 1'b1);
    for (int i = 7; i > 0; i--) press(1'b0, 1'b1, 3'(i), 3'(i - 1), 1'b0);
    press(1'b0, 1'b1, 3'd0, 3'd0, 1'b1);

    press(1'b1, 1'b1, 3'd0, 3'd0, 1'b0);
    press(1'b1, 1'b0, 3'd0, 3'd1, 1'b0);
    enable_f = 1'b0;
    press(1'b1, 1'b0, 3'd1, 3'd1, 1'b0);
    enable_f = 1'b1;
    step(20);
    chk("duty_before_reset", {5'd0, duty_f}, 8'd1);

    // Reset while up press is arming; button still held at release.
    up_f = 1'b1;
    step(4);
    reset_f = 1'b1;
    #1;
    chk("async_reset_level", {5'd0, level_f}, 8'd0);
    chk("async_reset_duty", {5'd0, duty_f}, 8'd0);
    chk("async_reset_pwm", {7'd0, pwm_f}, 8'd0);
    chk("async_reset_sat", {7'd0, sat_f}, 8'd0);
    step(2);
    reset_f = 1'b0;
    pwm_leak = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (pwm_f) pwm_leak = 1'b1;
    end
    chk("post_reset_level_wait", {5'd0, level_f}, 8'd0);
    chk("post_reset_pwm_low", {7'd0, pwm_leak}, 8'd0);
    step(1);
    chk("post_reset_level_inc", {5'd0, level_f}, 8'd1);
    step(12);
    chk("post_reset_single_inc", {5'd0, level_f}, 8'd1);
    up_f = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
